// File: rtl/count_mon_pkg.sv
// count_mon_pkg
//   Shared definitions for the count_monitor block: the tracking state
//   enumeration and the width / saturation limit of the error counter.
//   Optional feature macro used by the block: COUNT_MON_ERR_FIFO_EN.

package count_mon_pkg;

  localparam int ERR_CNT_W = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 4'd15;

  // IDLE : no reference value held
  // SYNC : reference held, counting direction not yet known
  // TRACK: direction known, every sample must be a +/-1 step
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } mon_state_e;

endpackage

// File: rtl/count_mon_fifo.sv
// count_mon_fifo
//   Small synchronous FIFO holding offending sample values for the
//   count_monitor error stream. The head entry is always presented on
//   valid_o/data_o; it leaves when valid_o and ready_i are both high.
//   A push into a full FIFO is dropped unless a pop happens in the same
//   cycle, in which case both succeed.
//   Only instantiated when COUNT_MON_ERR_FIFO_EN is defined.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset, empties the FIFO
//   push_i     : write pushData_i this cycle
//   pushData_i : value to store
//   ready_i    : consumer accepts the head entry
//   valid_o    : head entry present
//   data_o     : head entry value (zero when empty)

module count_mon_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] pushData_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  // DEPTH is a power of two, so the pointers wrap on their own
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          full;
  logic          pop;
  logic          pushOk;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = valid_o & ready_i;
  assign pushOk  = push_i & (~full | pop);
  assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({pushOk, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor
//   Watches the value bus of an up/down counter and checks that it only
//   ever moves by one step per accepted sample. It learns the direction,
//   reports lock, flags wrap-around steps and captures offending values
//   in an error store drained through a valid/ready stream.
//
//   Macro COUNT_MON_ERR_FIFO_EN: when defined the error store is a
//   FIFO_DEPTH-entry FIFO (count_mon_fifo); otherwise it is a single
//   register holding the first unpopped error.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   ena       : monitor enable; low freezes state and suppresses wrap
//   cnt_in    : observed counter value
//   cnt_vld   : counter bus driven
//   ld_seen   : current sample comes from a counter load
//   cur_val   : last accepted sample
//   dir       : tracked direction (1 up, 0 down)
//   locked    : high while in TRACK
//   wrap      : one-cycle pulse on an accepted max->0 or 0->max step
//   err_cnt   : saturating error count
//   err_data  : oldest stored offending sample
//   err_valid : error store not empty
//   err_ready : consumer pops err_data

module count_monitor
  import count_mon_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOAD_ALIGN = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [DATA_W-1:0]    cnt_in,
  input  logic                 cnt_vld,
  input  logic                 ld_seen,
  output logic [DATA_W-1:0]    cur_val,
  output logic                 dir,
  output logic                 locked,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [DATA_W-1:0]    err_data,
  output logic                 err_valid,
  input  logic                 err_ready
);

  localparam logic [DATA_W-1:0] LOAD_MASK = DATA_W'((64'd1 << LOAD_ALIGN) - 64'd1);
  localparam logic [DATA_W-1:0] MAX_VAL   = {DATA_W{1'b1}};

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadDepth
    $error("count_monitor: FIFO_DEPTH must be a power of two >= 2");
  end

  mon_state_e             state_q, state_d;
  logic [DATA_W-1:0]      refVal_q, refVal_d;
  logic [DATA_W-1:0]      curVal_q, curVal_d;
  logic                   dir_q, dir_d;
  logic                   locked_q;
  logic                   wrap_q, wrap_d;
  logic [ERR_CNT_W-1:0]   errCnt_q;
  logic                   errPush;
  logic [DATA_W-1:0]      refPlus;
  logic [DATA_W-1:0]      refMinus;
  logic                   loadAligned;
  logic                   stepAccept;

  assign refPlus     = refVal_q + 1'b1;
  assign refMinus    = refVal_q - 1'b1;
  assign loadAligned = ((cnt_in & LOAD_MASK) == '0);

  // The reference is the value the next sample is compared against. It
  // follows every valid sample, including rejected ones, so tracking
  // resynchronises on whatever the counter shows after a glitch. cur_val
  // only follows samples that were accepted.
  always_comb begin
    state_d    = state_q;
    refVal_d   = refVal_q;
    curVal_d   = curVal_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    errPush    = 1'b0;
    stepAccept = 1'b0;

    if (ena) begin
      if (!cnt_vld) begin
        state_d = IDLE;
      end else if (ld_seen) begin
        state_d  = SYNC;
        refVal_d = cnt_in;
        if (loadAligned) begin
          curVal_d = cnt_in;
        end else begin
          errPush = 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_d  = SYNC;
            refVal_d = cnt_in;
            curVal_d = cnt_in;
          end
          SYNC, TRACK: begin
            if (cnt_in == refPlus) begin
              stepAccept = 1'b1;
              dir_d      = 1'b1;
            end else if (cnt_in == refMinus) begin
              stepAccept = 1'b1;
              dir_d      = 1'b0;
            end else begin
              errPush  = 1'b1;
              state_d  = SYNC;
              refVal_d = cnt_in;
            end
            if (stepAccept) begin
              state_d  = TRACK;
              refVal_d = cnt_in;
              curVal_d = cnt_in;
              wrap_d   = ((refVal_q == MAX_VAL) && (cnt_in == '0)) ||
                         ((refVal_q == '0) && (cnt_in == MAX_VAL));
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      refVal_q <= '0;
      curVal_q <= '0;
      dir_q    <= 1'b1;
      locked_q <= 1'b0;
      wrap_q   <= 1'b0;
      errCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      refVal_q <= refVal_d;
      curVal_q <= curVal_d;
      dir_q    <= dir_d;
      locked_q <= (state_d == TRACK);
      wrap_q   <= wrap_d;
      if (errPush && (errCnt_q != ERR_CNT_MAX)) begin
        errCnt_q <= errCnt_q + 1'b1;
      end
    end
  end

  assign cur_val = curVal_q;
  assign dir     = dir_q;
  assign locked  = locked_q;
  assign wrap    = wrap_q;
  assign err_cnt = errCnt_q;

`ifdef COUNT_MON_ERR_FIFO_EN

  count_mon_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) uErrFifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (errPush),
    .pushData_i (cnt_in),
    .ready_i    (err_ready),
    .valid_o    (err_valid),
    .data_o     (err_data)
  );

`else

  logic              errHeld_q;
  logic [DATA_W-1:0] errHeldData_q;
  logic              errPop;

  assign errPop = errHeld_q & err_ready;

  // Single-entry store: keeps the first unpopped error. A new error in the
  // same cycle as a pop replaces the departing entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errHeld_q     <= 1'b0;
      errHeldData_q <= '0;
    end else if (errPush && (!errHeld_q || errPop)) begin
      errHeld_q     <= 1'b1;
      errHeldData_q <= cnt_in;
    end else if (errPop) begin
      errHeld_q     <= 1'b0;
      errHeldData_q <= '0;
    end
  end

  assign err_valid = errHeld_q;
  assign err_data  = errHeldData_q;

`endif

endmodule
